// File: rtl/div_seq.sv
// Sequencer for a radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic                 signed_q, signed_d;

    logic [WIDTH-1:0]     op1_mag, op2_mag;
    logic [WIDTH:0]       rem_sh;
    logic signed [WIDTH:0] trial;
    logic [WIDTH-1:0]     rem_nx, quo_nx;
    logic                 stall_c, ready_c;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[WIDTH-1]);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        signed_d  = signed_q;
        stall_c   = 1'b0;
        ready_c   = 1'b0;

        op1_mag = abs_val(opdata1_i, signed_i);
        op2_mag = abs_val(opdata2_i, signed_i);

        // One restoring step: shift in the next dividend bit, keep the trial if non-negative.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = $signed(rem_sh - {1'b0, divisor_q});
        rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    stall_c   = 1'b1;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = op1_mag;
                    divisor_d = op2_mag;
                    signed_d  = signed_i;
                    neg_q_d   = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r_d   = signed_i & opdata1_i[WIDTH-1];
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
`ifdef DIV_EARLY_OUT_EN
                        if (op1_mag < op2_mag) begin
                            state_d  = S_END;
                            result_d = {cond_neg(op1_mag, signed_i & opdata1_i[WIDTH-1]), {WIDTH{1'b0}}};
                        end else begin
                            state_d = S_ON;
                        end
`else
                        state_d = S_ON;
`endif
                    end
                end
            end
            S_DIVZERO: begin
                stall_c = ~annul_i;
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                end
            end
            S_ON: begin
                stall_c = ~annul_i;
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d  = S_END;
                        result_d = {cond_neg(rem_nx, neg_r_q), cond_neg(quo_nx, neg_q_q)};
                    end
                end
            end
            S_END: begin
                ready_c = ~annul_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Datapath registers carry no reset; the FSM decides when they are meaningful.
    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        divisor_q <= divisor_d;
        neg_q_q   <= neg_q_d;
        neg_r_q   <= neg_r_d;
        signed_q  <= signed_d;
    end

    assign result_o = result_q;
    assign ready_o  = ready_c & ~rst;
    assign stall_o  = stall_c & ~rst;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, results, stall, annul, reset, overflow.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int checks   = 0;
    int failures = 0;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int   lat;
        int   stall_cnt;
        logic got;
        logic end_stall;
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = sg;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        stall_cnt = stall_o ? 1 : 0;
        lat       = 0;
        got       = 1'b0;
        end_stall = 1'b1;
        while (!got && lat < 60) begin
            @(negedge clk);
            start_i = 1'b0;
            lat++;
            #1;
            if (ready_o) begin
                got       = 1'b1;
                end_stall = stall_o;
            end else if (stall_o) begin
                stall_cnt++;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result_o, exp_res);
        check({tag, " stall cycles"}, 64'(stall_cnt), 64'(exp_lat));
        check({tag, " stall in END"}, 64'(end_stall), 64'd0);
        @(negedge clk);
        #1;
        check({tag, " ready pulse"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        int ready_seen;
        int stall_seen;
        int early_lat;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset result", result_o, 64'd0);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33, {32'h2, 32'hE});
        repeat (4) @(negedge clk);
        #1;
        check("result held", result_o, {32'h2, 32'hE});

        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 33, {32'h1, 32'hFFFF_FFFD});
        do_div("divu fff9/2", 1'b0, 32'hFFFF_FFF9, 32'h2, 33, {32'h1, 32'h7FFF_FFFC});
        do_div("divu max/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, {32'h0, 32'h1});
        do_div("divu 5/0", 1'b0, 32'd5, 32'd0, 2, 64'd0);

        // Annul in the middle of an iteration.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul stall same cycle", 64'(stall_o), 64'd0);
        @(negedge clk);
        annul_i    = 1'b0;
        ready_seen = 0;
        stall_seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready_o) ready_seen++;
            if (stall_o) stall_seen++;
            @(negedge clk);
        end
        check("annul no ready", 64'(ready_seen), 64'd0);
        check("annul stall low", 64'(stall_seen), 64'd0);
        do_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3});

        do_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});

        // Reset in the middle of a division.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready_o) ready_seen++;
            @(negedge clk);
        end
        check("mid reset no ready", 64'(ready_seen), 64'd0);
        check("mid reset result", result_o, 64'd0);

`ifdef DIV_EARLY_OUT_EN
        early_lat = 1;
`else
        early_lat = 33;
`endif
        do_div("divu 3/10", 1'b0, 32'd3, 32'd10, early_lat, {32'h3, 32'h0});
        do_div("div -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, early_lat, {32'hFFFF_FFFD, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
